// File: rtl/fx_arith_unit.sv
// Pipelined signed fixed-point multiply (OP=0) or divide (OP=1) with valid/ready streaming.
// Define FX_SATURATE_EN to clip overflowing results; otherwise they wrap to the low WIDTH bits.
module fx_arith_unit #(
    parameter int WIDTH       = 32,
    parameter int QINT        = 15,
    parameter int QFRAC       = 16,
    parameter int OP          = 0,
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int L  = (OP == 0) ? MUL_LATENCY : DIV_LATENCY;
    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH != 1 + QINT + QFRAC) begin : g_bad_format
        $error("fx_arith_unit: WIDTH must equal 1 + QINT + QFRAC");
    end
    if (L < 1) begin : g_bad_latency
        $error("fx_arith_unit: latency must be at least 1");
    end

    logic signed [W2-1:0] a_ext;
    logic signed [W2-1:0] b_ext;
    logic signed [W2-1:0] b_safe;
    logic signed [W2-1:0] wide;
    logic        [WIDTH:0] top_bits;
    logic                  fits;
    logic [WIDTH-1:0]      res_c;
    logic                  ovf_c;

    // Compute-then-delay: the whole operation is evaluated at 2*WIDTH precision
    // on entry, and the remaining stages only carry the finished result.
    always_comb begin
        a_ext  = {{WIDTH{a[WIDTH-1]}}, a};
        b_ext  = {{WIDTH{b[WIDTH-1]}}, b};
        b_safe = (b == '0) ? W2'(1) : b_ext;
        if (OP == 0) begin
            wide = (a_ext * b_ext) >>> QFRAC;
        end else begin
            wide = (a_ext <<< QFRAC) / b_safe;
        end
        top_bits = wide[W2-1:WIDTH-1];
        fits     = (&top_bits) || !(|top_bits);
        ovf_c    = !fits;
        res_c    = wide[WIDTH-1:0];
`ifdef FX_SATURATE_EN
        if (!fits) begin
            res_c = wide[W2-1] ? MIN_V : MAX_V;
        end
`endif
        // Division by zero clips by the numerator's sign in both builds.
        if (OP != 0 && b == '0) begin
            ovf_c = 1'b1;
            res_c = a[WIDTH-1] ? MIN_V : MAX_V;
        end
    end

    logic             adv;
    logic [L-1:0]     stage_vld;
    logic [L-1:0]     stage_ovf;
    logic [WIDTH-1:0] stage_dat [L];

    assign adv       = ready_in || !valid_out;
    assign ready_out = adv;

    // NOTE: the data stages are reset too, because result must read 0 after reset;
    // with no reset on them a stale in-flight value could reappear on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld <= '0;
            stage_ovf <= '0;
            for (int i = 0; i < L; i++) begin
                stage_dat[i] <= '0;
            end
        end else if (adv) begin
            stage_vld[0] <= valid_in;
            stage_ovf[0] <= valid_in && ovf_c;
            stage_dat[0] <= valid_in ? res_c : '0;
            for (int i = 1; i < L; i++) begin
                stage_vld[i] <= stage_vld[i-1];
                stage_ovf[i] <= stage_ovf[i-1];
                stage_dat[i] <= stage_dat[i-1];
            end
        end
    end

    assign valid_out = stage_vld[L-1];
    assign result    = stage_dat[L-1];
    assign ovf       = stage_ovf[L-1];

endmodule

// File: tb/tb_fx_arith_unit.sv
// Drives a multiply unit and a divide unit with shared stimulus and scoreboards both
// against a longint reference model; honours FX_SATURATE_EN the same way as the design.
module tb_fx_arith_unit;

    localparam int MUL_L = 3;
    localparam int DIV_L = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        ready_out_m, valid_out_m, ovf_m;
    logic        ready_out_d, valid_out_d, ovf_d;
    logic [31:0] result_m, result_d;

    int n_pass  = 0;
    int n_total = 0;

    logic [32:0] q_mul[$];
    logic [32:0] q_div[$];

    always #5 clk = ~clk;

    fx_arith_unit #(.WIDTH(32), .QINT(15), .QFRAC(16), .OP(0),
                    .MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L)) u_mul (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out_m),
        .a(a), .b(b), .valid_out(valid_out_m), .ready_in(ready_in),
        .result(result_m), .ovf(ovf_m)
    );

    fx_arith_unit #(.WIDTH(32), .QINT(15), .QFRAC(16), .OP(1),
                    .MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L)) u_div (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out_d),
        .a(a), .b(b), .valid_out(valid_out_d), .ready_in(ready_in),
        .result(result_d), .ovf(ovf_d)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers; returns {ovf, result}.
    function automatic logic [32:0] model(input bit op, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'(signed'(x));
        longint sy = longint'(signed'(y));
        longint r;
        if (op) begin
            if (y == 0) return {1'b1, x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF};
            r = (sx * 65536) / sy;
        end else begin
            r = (sx * sy) >>> 16;
        end
        if (r > 64'sd2147483647 || r < -64'sd2147483648) begin
`ifdef FX_SATURATE_EN
            return {1'b1, (r < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF};
`else
            return {1'b1, r[31:0]};
`endif
        end
        return {1'b0, r[31:0]};
    endfunction

    // Scoreboard: record accepted beats, compare every valid output, retire on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_out_m) begin
                if (q_mul.size() == 0) check("mul_unexpected_beat", 1, 0);
                else begin
                    check("mul_stream", {ovf_m, result_m}, q_mul[0]);
                    if (ready_in) void'(q_mul.pop_front());
                end
            end
            if (valid_out_d) begin
                if (q_div.size() == 0) check("div_unexpected_beat", 1, 0);
                else begin
                    check("div_stream", {ovf_d, result_d}, q_div[0]);
                    if (ready_in) void'(q_div.pop_front());
                end
            end
            if (valid_in && ready_out_m) q_mul.push_back(model(1'b0, a, b));
            if (valid_in && ready_out_d) q_div.push_back(model(1'b1, a, b));
        end
    end

    // Single beat with downstream ready; checks latency and a hand-computed result.
    task automatic directed(input bit op, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp_r, input bit exp_o, input string name);
        int k;
        bit seen;
        ready_in = 1'b1;
        valid_in = 1'b1;
        a = x;
        b = y;
        seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            if (op ? valid_out_d : valid_out_m) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 1, 0);
        else begin
            check({name, "_latency"}, k, op ? DIV_L : MUL_L);
            check({name, "_result"}, op ? result_d : result_m, exp_r);
            check({name, "_ovf"}, op ? ovf_d : ovf_m, exp_o);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #1;
        check("reset_valid_m", valid_out_m, 0);
        check("reset_result_m", result_m, 0);
        check("reset_ovf_d", ovf_d, 0);
        check("reset_ready_m", ready_out_m, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pin the reference model against hand-computed values.
        check("model_mul_1p5x2", model(1'b0, 32'h0001_8000, 32'h0002_0000), {1'b0, 32'h0003_0000});
        check("model_div_1div3", model(1'b1, 32'h0001_0000, 32'h0003_0000), {1'b0, 32'h0000_5555});

        directed(1'b0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0, "mul_1p5x2");
        directed(1'b0, 32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 1'b0, "mul_neg");
`ifdef FX_SATURATE_EN
        directed(1'b0, 32'h00C8_0000, 32'h00C8_0000, 32'h7FFF_FFFF, 1'b1, "mul_ovf");
`else
        directed(1'b0, 32'h00C8_0000, 32'h00C8_0000, 32'h9C40_0000, 1'b1, "mul_ovf");
`endif
        directed(1'b1, 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, "div_1div3");
        directed(1'b1, 32'hFFFF_0000, 32'h0002_0000, 32'hFFFF_8000, 1'b0, "div_neg");
        directed(1'b1, 32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, "div_by_zero_pos");
        directed(1'b1, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, "div_by_zero_neg");

        // Eight back-to-back beats; ready_out must never drop.
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            a = 32'h0001_0000 * (i + 1);
            b = 32'h0000_8000 + 32'(i);
            @(posedge clk);
            #1;
            check("stream_ready_m", ready_out_m, 1);
            check("stream_ready_d", ready_out_d, 1);
        end
        valid_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("stream_drained_m", q_mul.size(), 0);
        check("stream_drained_d", q_div.size(), 0);

        // Stall for three cycles with results waiting.
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1;
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_ready_m", ready_out_m, 0);
            check("stall_ready_d", ready_out_d, 0);
        end
        ready_in = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("stall_drained_m", q_mul.size(), 0);
        check("stall_drained_d", q_div.size(), 0);

        // Reset with two beats in flight.
        for (int i = 0; i < 2; i++) begin
            valid_in = 1'b1;
            a = 32'h0003_0000;
            b = 32'h0001_0000;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid_m", valid_out_m, 0);
        check("midrst_result_m", result_m, 0);
        check("midrst_ovf_m", ovf_m, 0);
        check("midrst_valid_d", valid_out_d, 0);
        q_mul.delete();
        q_div.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("postrst_ready_m", ready_out_m, 1);
        check("postrst_ready_d", ready_out_d, 1);
        repeat (4) @(posedge clk);
        #1;
        check("postrst_no_ghost_m", valid_out_m, 0);
        directed(1'b0, 32'h0002_0000, 32'h0002_0000, 32'h0004_0000, 1'b0, "mul_after_reset");

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 3) != 0);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) a = {{12{a[31]}}, a[31:12]};
            if ($urandom_range(0, 2) == 1) b = {{8{b[31]}}, b[31:8]};
            if ($urandom_range(0, 15) == 0) b = 32'h0;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("random_drained_m", q_mul.size(), 0);
        check("random_drained_d", q_div.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
